// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC handshake controllers.
package cdc_pkg;

   // Shortest chain that still acts as a metastability synchroniser.
   localparam int unsigned SYNC_STAGES_MIN = 2;

   // Source-side 4-phase handshake states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ_HI = 2'd1,
      ST_REQ_LO = 2'd2,
      ST_ERR    = 2'd3
   } hs_state_e;

endpackage : cdc_pkg

// File: rtl/m_ff_sync.sv
// Single-bit flop-chain synchroniser, clears to 0 on reset.
module m_ff_sync
   import cdc_pkg::*;
#(
   parameter int unsigned NUM_FF = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   // Chains shorter than the minimum give no metastability settling time; floor the length.
   localparam int unsigned STAGES = (NUM_FF < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : NUM_FF;

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the asynchronous input one stage per clock.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Chain registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule : m_ff_sync

// File: rtl/cdc_hs_tx_ctrl.sv
// Source-side 4-phase req/ack CDC controller with ack synchroniser and phase watchdog.
module cdc_hs_tx_ctrl
   import cdc_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_req,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_ack,
   output logic              o_done,
   output logic              o_err,
   input  logic              i_clr_err
);

   hs_state_e             state_q, state_d;
   logic                  req_q, req_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  drain_q, drain_d;
   logic [TIMEOUT_W-1:0]  wd_q, wd_d;
   logic                  ack_s;
   logic                  wd_hit;

   // Bring the destination ack into this clock domain.
   m_ff_sync #(
      .NUM_FF (SYNC_STAGES)
   ) u_ack_sync (
      .clk   (clk),
      .rst_n (~rst),
      .d     (i_ack),
      .q     (ack_s)
   );

   // A new word may only start once the previous ack has fully returned low.
   assign o_ready = (state_q == ST_IDLE) && !ack_s;
   assign wd_hit  = &wd_q;

   // Handshake sequencing, watchdog and output register next-state.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = err_q;
      drain_d = drain_q;
      wd_d    = wd_q;

      case (state_q)
         ST_IDLE: begin
            if (i_valid && o_ready) begin
               data_d  = i_data;
               req_d   = 1'b1;
               state_d = ST_REQ_HI;
            end
         end
         ST_REQ_HI: begin
            // Ack is checked first so a same-edge timeout never wins.
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = ST_REQ_LO;
            end else if (wd_hit) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = ST_ERR;
            end
         end
         ST_REQ_LO: begin
            if (!ack_s) begin
               // A drain after error recovery is not a completed transfer.
               done_d  = !drain_q;
               drain_d = 1'b0;
               state_d = ST_IDLE;
            end else if (wd_hit) begin
               err_d   = 1'b1;
               drain_d = 1'b0;
               state_d = ST_ERR;
            end
         end
         ST_ERR: begin
            req_d = 1'b0;
            err_d = 1'b1;
            if (i_clr_err) begin
               err_d   = 1'b0;
               drain_d = 1'b1;
               state_d = ST_REQ_LO;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      // Watchdog restarts each phase and saturates at all-ones.
      if (state_d != state_q) begin
         wd_d = '0;
      end else if (((state_q == ST_REQ_HI) || (state_q == ST_REQ_LO)) && !wd_hit) begin
         wd_d = wd_q + TIMEOUT_W'(1);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         drain_q <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
         drain_q <= drain_d;
         wd_q    <= wd_d;
      end
   end

   assign o_req  = req_q;
   assign o_data = data_q;
   assign o_done = done_q;
   assign o_err  = err_q;

endmodule : cdc_hs_tx_ctrl

// File: tb/tb_cdc_hs_tx_ctrl.sv
// Scenario bench for cdc_hs_tx_ctrl with a word scoreboard on the destination side.
module tb_cdc_hs_tx_ctrl;

   localparam int unsigned DATA_W = 32;
   localparam int          SYNC   = 2;
   localparam int          TW     = 4;
   localparam int          WD_LIMIT = (1 << TW);

   logic              clk;
   logic              rst;
   logic              i_valid;
   logic              o_ready;
   logic [DATA_W-1:0] i_data;
   logic              o_req;
   logic [DATA_W-1:0] o_data;
   logic              i_ack;
   logic              o_done;
   logic              o_err;
   logic              i_clr_err;

   int total    = 0;
   int bad      = 0;
   int done_cnt = 0;
   int acc_cnt  = 0;
   logic [DATA_W-1:0] exp_q[$];

   cdc_hs_tx_ctrl #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC),
      .TIMEOUT_W   (TW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_data    (i_data),
      .o_req     (o_req),
      .o_data    (o_data),
      .i_ack     (i_ack),
      .o_done    (o_done),
      .o_err     (o_err),
      .i_clr_err (i_clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses and accepts as seen just before each edge.
   always @(posedge clk) begin
      if (o_done === 1'b1) done_cnt++;
      if (i_valid === 1'b1 && o_ready === 1'b1 && rst === 1'b0) acc_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench stalled");
   end

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ack = 1'b0; i_clr_err = 1'b0;
      cyc(3);
      rst = 1'b0;
      total++; if (o_req !== 1'b0)   begin bad++; $display("FAIL reset_req: got %b want 0", o_req); end
      total++; if (o_data !== '0)    begin bad++; $display("FAIL reset_data: got %h want 0", o_data); end
      total++; if (o_done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
      total++; if (o_err !== 1'b0)   begin bad++; $display("FAIL reset_err: got %b want 0", o_err); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
   endtask

   task automatic test_basic();
      logic [DATA_W-1:0] w;
      int n, nd, at, d0;
      bit hold_ok;
      d0 = done_cnt; hold_ok = 1'b1; nd = 0; at = -1;
      i_data = 32'hDEADBEEF; i_valid = 1'b1; exp_q.push_back(32'hDEADBEEF);
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", o_ready); end
      @(negedge clk); i_valid = 1'b0; i_data = '0;
      total++; if (o_req !== 1'b1) begin bad++; $display("FAIL basic_req_latency: got %b want 1", o_req); end
      w = exp_q.pop_front();
      total++; if (o_data !== w) begin bad++; $display("FAIL basic_data: got %h want %h", o_data, w); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (o_data !== w || o_req !== 1'b1) hold_ok = 1'b0;
      end
      i_ack = 1'b1;
      n = 0;
      while (o_req === 1'b1 && n < 20) begin
         @(negedge clk); n++;
         if (o_data !== w) hold_ok = 1'b0;
      end
      total++; if (n != SYNC + 1) begin bad++; $display("FAIL basic_ack_to_req_fall: got %0d want %0d", n, SYNC + 1); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (o_data !== w || o_req !== 1'b0) hold_ok = 1'b0;
      end
      i_ack = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (o_data !== w) hold_ok = 1'b0;
         if (at >= 0 && k == at + 1) begin
            total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_after_done: got %b want 1", o_ready); end
         end
         if (o_done === 1'b1) begin nd++; at = k; end
      end
      total++; if (nd != 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", nd); end
      total++; if (!hold_ok) begin bad++; $display("FAIL basic_data_hold: got unstable want %h", w); end
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_back_to_back();
      int d0, a0;
      d0 = done_cnt; a0 = acc_cnt;
      fork
         begin : source
            int n;
            for (int i = 0; i < 4; i++) begin
               i_data = 32'h0000_00A0 + DATA_W'(i); i_valid = 1'b1;
               exp_q.push_back(32'h0000_00A0 + DATA_W'(i));
               n = 0;
               while (o_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
               if (n >= 200) begin total++; bad++; $display("FAIL b2b_accept_timeout: got %0d want <200", n); end
               @(negedge clk);
            end
            i_valid = 1'b0; i_data = '0;
         end
         begin : dest
            logic [DATA_W-1:0] w;
            int n;
            for (int t = 0; t < 4; t++) begin
               n = 0;
               while (o_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
               if (n >= 200) begin total++; bad++; $display("FAIL b2b_req_timeout: got %0d want <200", n); end
               if (exp_q.size() == 0) begin
                  total++; bad++; $display("FAIL b2b_extra_word: got %h want none", o_data);
               end else begin
                  w = exp_q.pop_front();
                  total++; if (o_data !== w) begin bad++; $display("FAIL b2b_word%0d: got %h want %h", t, o_data, w); end
               end
               cyc(2); i_ack = 1'b1;
               n = 0;
               while (o_req !== 1'b0 && n < 50) begin @(negedge clk); n++; end
               cyc(1); i_ack = 1'b0;
            end
         end
      join
      cyc(6);
      total++; if (done_cnt - d0 != 4) begin bad++; $display("FAIL b2b_done_count: got %0d want 4", done_cnt - d0); end
      total++; if (acc_cnt - a0 != 4)  begin bad++; $display("FAIL b2b_accept_count: got %0d want 4", acc_cnt - a0); end
      total++; if (exp_q.size() != 0)  begin bad++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_timeout();
      logic [DATA_W-1:0] w;
      int n, d0;
      d0 = done_cnt;
      i_data = 32'h0000_0055; i_valid = 1'b1; exp_q.push_back(32'h0000_0055);
      @(negedge clk); i_valid = 1'b0; i_data = '0;
      total++; if (o_req !== 1'b1) begin bad++; $display("FAIL to_req: got %b want 1", o_req); end
      w = exp_q.pop_front();
      total++; if (o_data !== w) begin bad++; $display("FAIL to_data: got %h want %h", o_data, w); end
      n = 0;
      while (o_err !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      total++; if (n != WD_LIMIT) begin bad++; $display("FAIL to_edges: got %0d want %0d", n, WD_LIMIT); end
      total++; if (o_req !== 1'b0) begin bad++; $display("FAIL to_req_drop: got %b want 0", o_req); end
      cyc(3);
      total++; if (o_err !== 1'b1)   begin bad++; $display("FAIL to_err_sticky: got %b want 1", o_err); end
      total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL to_ready_in_err: got %b want 0", o_ready); end
      total++; if (o_data !== w)     begin bad++; $display("FAIL to_data_hold: got %h want %h", o_data, w); end
      i_clr_err = 1'b1; @(negedge clk); i_clr_err = 1'b0;
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL to_err_clear: got %b want 0", o_err); end
      cyc(4);
      total++; if (o_ready !== 1'b1)   begin bad++; $display("FAIL to_ready_recover: got %b want 1", o_ready); end
      total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL to_no_done: got %0d want 0", done_cnt - d0); end
   endtask

   task automatic test_stuck_ack();
      int n;
      i_ack = 1'b1; cyc(4);
      rst = 1'b1; cyc(2); rst = 1'b0;
      total++; if (o_req !== 1'b0) begin bad++; $display("FAIL stuck_req: got %b want 0", o_req); end
      total++; if (o_data !== '0)  begin bad++; $display("FAIL stuck_data: got %h want 0", o_data); end
      cyc(SYNC + 1);
      total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL stuck_ready: got %b want 0", o_ready); end
      i_valid = 1'b1; i_data = 32'h0000_0077; cyc(3);
      total++; if (o_req !== 1'b0) begin bad++; $display("FAIL stuck_no_accept: got %b want 0", o_req); end
      i_valid = 1'b0; i_data = '0;
      i_ack = 1'b0;
      n = 0;
      while (o_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      total++; if (n != SYNC) begin bad++; $display("FAIL stuck_ready_delay: got %0d want %0d", n, SYNC); end
   endtask

   task automatic test_reset_mid();
      logic [DATA_W-1:0] w;
      int n, d0;
      d0 = done_cnt;
      i_data = 32'h1234_5678; i_valid = 1'b1; exp_q.push_back(32'h1234_5678);
      @(negedge clk); i_valid = 1'b0; i_data = '0;
      w = exp_q.pop_front();
      total++; if (o_data !== w) begin bad++; $display("FAIL rmid_data: got %h want %h", o_data, w); end
      @(negedge clk);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      total++; if (o_req !== 1'b0)  begin bad++; $display("FAIL rmid_req: got %b want 0", o_req); end
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", o_done); end
      cyc(4);
      total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL rmid_spurious_done: got %0d want 0", done_cnt - d0); end
      total++; if (o_ready !== 1'b1)   begin bad++; $display("FAIL rmid_ready: got %b want 1", o_ready); end
      i_data = 32'hCAFE_F00D; i_valid = 1'b1; exp_q.push_back(32'hCAFE_F00D);
      @(negedge clk); i_valid = 1'b0; i_data = '0;
      w = exp_q.pop_front();
      total++; if (o_req !== 1'b1 || o_data !== w) begin bad++; $display("FAIL rmid_next_req: got %b/%h want 1/%h", o_req, o_data, w); end
      cyc(1); i_ack = 1'b1;
      n = 0;
      while (o_req !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      cyc(1); i_ack = 1'b0;
      n = 0;
      while (o_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      cyc(2);
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rmid_next_done: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_race();
      logic [DATA_W-1:0] w;
      int n, d0;
      d0 = done_cnt;
      i_data = 32'hA5A5_5A5A; i_valid = 1'b1; exp_q.push_back(32'hA5A5_5A5A);
      @(negedge clk); i_valid = 1'b0; i_data = '0;
      w = exp_q.pop_front();
      total++; if (o_req !== 1'b1 || o_data !== w) begin bad++; $display("FAIL race_req: got %b/%h want 1/%h", o_req, o_data, w); end
      // Ack enters the chain so the synchronised copy rises with the watchdog's last increment.
      cyc(WD_LIMIT - 3);
      i_ack = 1'b1;
      cyc(3);
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL race_err: got %b want 0", o_err); end
      total++; if (o_req !== 1'b0) begin bad++; $display("FAIL race_req_fall: got %b want 0", o_req); end
      cyc(2); i_ack = 1'b0;
      n = 0;
      while (o_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      cyc(2);
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL race_done: got %0d want 1", done_cnt - d0); end
      total++; if (o_err !== 1'b0)     begin bad++; $display("FAIL race_err_final: got %b want 0", o_err); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_timeout();
      test_stuck_ack();
      test_reset_mid();
      test_race();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cdc_hs_tx_ctrl
